noc_packetizer: RTL and testbench
=================================

// Module: noc_packetizer
// PURPOSE
//  Injection-side network interface: turns one packet request (dest coords + payload beats) into HEAD/BODY/TAIL flits.
//  Drives one router input port (flit/valid/ready); the router is the switch, this block is the endpoint transmitter.
//  Registered output, one flit/cycle sustained when ready_in stays high.
// PARAMETERS
//  FLIT_WIDTH  64  flit width; payload beat = FLIT_WIDTH-2 bits (top 2 bits = flit type)
//  COORD_W     4   mesh X/Y coordinate width
//  LEN_W       8   payload beat count width (0..2^LEN_W-1 beats)
//  SRC_X       0   this node's X coordinate (inserted in head)
//  SRC_Y       0   this node's Y coordinate (inserted in head)
// PORTS
//  clk        in   1             clock; all logic on rising edge
//  rst_n      in   1             asynchronous active-low reset
//  req_valid  in   1             packet request valid
//  req_ready  out  1             request accepted when req_valid&&req_ready
//  req_dst_x  in   COORD_W       destination X
//  req_dst_y  in   COORD_W       destination Y
//  req_len    in   LEN_W         number of payload beats to follow (0 legal)
//  data_valid in   1             payload beat valid
//  data_ready out  1             payload beat accepted when data_valid&&data_ready
//  data_in    in   FLIT_WIDTH-2  payload beat
//  flit_out   out  FLIT_WIDTH    flit to router input port
//  valid_out  out  1             flit valid
//  ready_in   in   1             router accepts flit
//  busy       out  1             high from request accept until last flit of packet accepted
// BEHAVIOUR
//  Flit type [FW-1:FW-2]: 00 HEAD, 01 BODY, 10 TAIL, 11 HEAD_TAIL.
//  Head fields below type, MSB first: dst_x, dst_y, src_x, src_y, len (LEN_W); remaining LSBs zero.
//  Body/tail: data_in copied unmodified to [FW-3:0].
//  Reset: valid_out=0, flit_out=0, req_ready=0, data_ready=0, busy=0, FSM=IDLE, counters 0.
//  Handshake: once valid_out=1, flit_out held stable until ready_in=1; valid_out never drops without acceptance.
//  slot_free = !valid_out || ready_in. Output register loads only when slot_free.
//  FSM IDLE:  req_ready=slot_free. On accept: load head, rem<=req_len, busy<=1.
//             req_len==0 -> type HEAD_TAIL, stay IDLE (busy clears when it is accepted); else -> BODY.
//  FSM BODY:  data_ready=slot_free, req_ready=0. On beat accept: load BODY if rem>1 else TAIL; rem<=rem-1.
//             TAIL loaded -> IDLE. busy clears when the TAIL is accepted.
//  Latency: request accept -> head valid next cycle; beat accept -> flit valid next cycle.
//  Back-to-back: new request accepted in the same cycle the previous TAIL is accepted (no bubble).
//  data_valid in IDLE ignored (data_ready=0); req_valid in BODY ignored.
//  ready_in low: all upstream readies low while output register full; no flit lost or duplicated.
//  Reset mid-packet: partial packet abandoned, outputs to reset values; downstream reset together.
// CONFIGURATION
//  NOC_PKT_CRC_EN defined: after last payload beat an extra TAIL flit carries CRC-16 in [15:0], other bits 0.
//    All payload flits then typed BODY; req_len==0 gives HEAD then CRC TAIL (never HEAD_TAIL).
//    CRC-16-CCITT, poly 0x1021, init 0xFFFF per packet, over each beat's FW-2 bits MSB first.
//    Head len field still = payload beat count. Added state: CRC after last beat, before IDLE.
//  Undefined: no CRC flit, no CRC logic; behaviour exactly as above.
// STRUCTURE
//  noc_pkg: flit type enum, head field offsets/widths, HEAD/BODY/TAIL encode helpers; shared with router, depacketizer.
//  Sub-module noc_crc16 (combinational next-CRC over one beat), instantiated only under NOC_PKT_CRC_EN.
// TESTING
//  1 Request dst=(3,2), len=2, beats A,B; ready_in=1 -> HEAD(dst 3,2, src 0,0, len 2), BODY A, TAIL B on 3 consecutive cycles.
//  2 Request len=0 -> single HEAD_TAIL flit; busy high exactly 1 cycle; next request accepted same cycle it leaves.
//  3 len=4, ready_in low 5 cycles mid-packet -> flit_out stable, data_ready=0, then 4 payload flits in order, none lost.
//  4 Two back-to-back len=1 packets, ready_in=1 -> HEAD,TAIL,HEAD,TAIL with no idle cycle between.
//  5 rst_n low during BODY of len=3 packet -> valid_out=0, busy=0 immediately; fresh len=1 packet afterwards correct.
//  6 NOC_PKT_CRC_EN, len=1 beat 0 -> HEAD, BODY 0, TAIL with CRC equal to reference-model CRC-16 of 62 zero bits.

Source files
------------

// File: rtl/noc_pkg.sv
// rtl/noc_pkg.sv - shared NoC flit types, packetizer states and CRC constants
package noc_pkg;

  localparam int FLIT_TYPE_W = 2;
  localparam logic [15:0] CRC16_POLY = 16'h1021;
  localparam logic [15:0] CRC16_INIT = 16'hFFFF;

  typedef enum logic [FLIT_TYPE_W-1:0] {
    FLIT_HEAD      = 2'b00,
    FLIT_BODY      = 2'b01,
    FLIT_TAIL      = 2'b10,
    FLIT_HEAD_TAIL = 2'b11
  } flit_type_e;

  typedef enum logic [1:0] {
    PKT_IDLE = 2'd0,
    PKT_BODY = 2'd1,
    PKT_CRC  = 2'd2
  } pkt_state_e;

  // TAIL and HEAD_TAIL both close a packet; the type MSB marks that.
  function automatic logic flit_is_last(input logic [FLIT_TYPE_W-1:0] t);
    return t[1];
  endfunction

endpackage

// File: rtl/noc_crc16.sv
// rtl/noc_crc16.sv - combinational CRC-16-CCITT update over one payload beat, MSB first
module noc_crc16
  import noc_pkg::*;
#(
  parameter int DW = 62
) (
  input  logic [15:0]   crc_in,
  input  logic [DW-1:0] data,
  output logic [15:0]   crc_out
);

  always_comb begin
    logic [15:0] c;
    c = crc_in;
    for (int i = DW - 1; i >= 0; i--) begin
      if (c[15] ^ data[i]) c = {c[14:0], 1'b0} ^ CRC16_POLY;
      else                 c = {c[14:0], 1'b0};
    end
    crc_out = c;
  end

endmodule

// File: rtl/noc_packetizer.sv
// rtl/noc_packetizer.sv - NoC injection packetizer: request + beats to HEAD/BODY/TAIL flits
// Optional trailing CRC-16 flit enabled by defining NOC_PKT_CRC_EN.
module noc_packetizer
  import noc_pkg::*;
#(
  parameter int FLIT_WIDTH = 64,
  parameter int COORD_W    = 4,
  parameter int LEN_W      = 8,
  parameter int SRC_X      = 0,
  parameter int SRC_Y      = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [COORD_W-1:0]      req_dst_x,
  input  logic [COORD_W-1:0]      req_dst_y,
  input  logic [LEN_W-1:0]        req_len,
  input  logic                    data_valid,
  output logic                    data_ready,
  input  logic [FLIT_WIDTH-3:0]   data_in,
  output logic [FLIT_WIDTH-1:0]   flit_out,
  output logic                    valid_out,
  input  logic                    ready_in,
  output logic                    busy
);

  localparam int PW      = FLIT_WIDTH - 2;
  localparam int DX_LSB  = PW - COORD_W;
  localparam int DY_LSB  = DX_LSB - COORD_W;
  localparam int SX_LSB  = DY_LSB - COORD_W;
  localparam int SY_LSB  = SX_LSB - COORD_W;
  localparam int LEN_LSB = SY_LSB - LEN_W;
  localparam logic [COORD_W-1:0] SRC_X_C = COORD_W'(SRC_X);
  localparam logic [COORD_W-1:0] SRC_Y_C = COORD_W'(SRC_Y);

  pkt_state_e             state_q, state_d;
  logic [LEN_W-1:0]       rem_q, rem_d;
  logic                   last_q;
  logic                   run_q;
  logic                   slot_free;
  logic                   load_en;
  logic [FLIT_WIDTH-1:0]  load_flit;
  logic [FLIT_WIDTH-1:0]  head_flit;
  flit_type_e             head_type;
  logic                   req_fire;

`ifdef NOC_PKT_CRC_EN
  logic [15:0] crc_q, crc_d, crc_next;

  noc_crc16 #(.DW(PW)) u_crc (
    .crc_in  (crc_q),
    .data    (data_in),
    .crc_out (crc_next)
  );

  assign head_type = FLIT_HEAD;
`else
  assign head_type = (req_len == '0) ? FLIT_HEAD_TAIL : FLIT_HEAD;
`endif

  assign slot_free = !valid_out || ready_in;
  assign req_fire  = req_valid && req_ready;

  always_comb begin
    head_flit = '0;
    head_flit[FLIT_WIDTH-1 -: 2]   = head_type;
    head_flit[DX_LSB +: COORD_W]   = req_dst_x;
    head_flit[DY_LSB +: COORD_W]   = req_dst_y;
    head_flit[SX_LSB +: COORD_W]   = SRC_X_C;
    head_flit[SY_LSB +: COORD_W]   = SRC_Y_C;
    head_flit[LEN_LSB +: LEN_W]    = req_len;
  end

  // run_q keeps both upstream readies low while reset is applied and one cycle after.
  always_comb begin
    state_d    = state_q;
    rem_d      = rem_q;
    req_ready  = 1'b0;
    data_ready = 1'b0;
    load_en    = 1'b0;
    load_flit  = '0;
`ifdef NOC_PKT_CRC_EN
    crc_d      = crc_q;
`endif
    case (state_q)
      PKT_IDLE: begin
        req_ready = slot_free && run_q;
        if (req_valid && req_ready) begin
          load_en   = 1'b1;
          load_flit = head_flit;
          rem_d     = req_len;
`ifdef NOC_PKT_CRC_EN
          crc_d   = CRC16_INIT;
          state_d = (req_len == '0) ? PKT_CRC : PKT_BODY;
`else
          state_d = (req_len == '0) ? PKT_IDLE : PKT_BODY;
`endif
        end
      end
      PKT_BODY: begin
        data_ready = slot_free && run_q;
        if (data_valid && data_ready) begin
          load_en = 1'b1;
          rem_d   = rem_q - 1'b1;
`ifdef NOC_PKT_CRC_EN
          load_flit = {FLIT_BODY, data_in};
          crc_d     = crc_next;
          if (rem_q == LEN_W'(1)) state_d = PKT_CRC;
`else
          if (rem_q > LEN_W'(1)) begin
            load_flit = {FLIT_BODY, data_in};
          end else begin
            load_flit = {FLIT_TAIL, data_in};
            state_d   = PKT_IDLE;
          end
`endif
        end
      end
      PKT_CRC: begin
`ifdef NOC_PKT_CRC_EN
        if (slot_free) begin
          load_en   = 1'b1;
          load_flit = {FLIT_TAIL, {(PW-16){1'b0}}, crc_q};
          state_d   = PKT_IDLE;
        end
`else
        state_d = PKT_IDLE;
`endif
      end
      default: state_d = PKT_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= PKT_IDLE;
      rem_q     <= '0;
      last_q    <= 1'b0;
      run_q     <= 1'b0;
      valid_out <= 1'b0;
      flit_out  <= '0;
      busy      <= 1'b0;
`ifdef NOC_PKT_CRC_EN
      crc_q     <= '0;
`endif
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      run_q   <= 1'b1;
`ifdef NOC_PKT_CRC_EN
      crc_q   <= crc_d;
`endif
      if (slot_free) begin
        valid_out <= load_en;
        if (load_en) begin
          flit_out <= load_flit;
          last_q   <= flit_is_last(load_flit[FLIT_WIDTH-1 -: 2]);
        end
      end
      // A new request in the same cycle the previous last flit leaves keeps busy high.
      if (req_fire)                          busy <= 1'b1;
      else if (valid_out && ready_in && last_q) busy <= 1'b0;
    end
  end

endmodule

// File: tb/tb_noc_packetizer.sv
// tb/tb_noc_packetizer.sv - scoreboard bench for noc_packetizer (default and NOC_PKT_CRC_EN builds)
module tb_noc_packetizer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  req_dst_x;
  logic [3:0]  req_dst_y;
  logic [7:0]  req_len;
  logic        data_valid;
  logic        data_ready;
  logic [61:0] data_in;
  logic [63:0] flit_out;
  logic        valid_out;
  logic        ready_in;
  logic        busy;

  int vec = 0;
  int mis = 0;
  int cyc = 0;
  logic [63:0] exp_q [$];
  int          acc_q [$];
  logic [61:0] pay   [$];

  noc_packetizer #(
    .FLIT_WIDTH(64), .COORD_W(4), .LEN_W(8), .SRC_X(0), .SRC_Y(0)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_dst_x  (req_dst_x),
    .req_dst_y  (req_dst_y),
    .req_len    (req_len),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .data_in    (data_in),
    .flit_out   (flit_out),
    .valid_out  (valid_out),
    .ready_in   (ready_in),
    .busy       (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vec++;
    assert (obs === exp) else begin
      mis++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] crc_ref(input logic [15:0] c_in, input logic [61:0] d);
    logic [15:0] c;
    c = c_in;
    for (int i = 61; i >= 0; i--) begin
      c = (c[15] != d[i]) ? ((c << 1) ^ 16'h1021) : (c << 1);
    end
    return c;
  endfunction

  task automatic push_pkt(input logic [3:0] dx, input logic [3:0] dy, input int len);
    logic [15:0] c;
    logic [1:0]  t;
    c = 16'hFFFF;
`ifdef NOC_PKT_CRC_EN
    exp_q.push_back({2'b00, dx, dy, 4'd0, 4'd0, 8'(len), 38'd0});
    for (int i = 0; i < len; i++) begin
      exp_q.push_back({2'b01, pay[i]});
      c = crc_ref(c, pay[i]);
    end
    exp_q.push_back({2'b10, 46'd0, c});
`else
    t = (len == 0) ? 2'b11 : 2'b00;
    exp_q.push_back({t, dx, dy, 4'd0, 4'd0, 8'(len), 38'd0});
    for (int i = 0; i < len; i++) begin
      t = (i == len - 1) ? 2'b10 : 2'b01;
      exp_q.push_back({t, pay[i]});
    end
`endif
  endtask

  always @(negedge clk) begin
    if (rst_n && valid_out && ready_in) begin
      acc_q.push_back(cyc);
      if (exp_q.size() == 0) begin
        vec++;
        mis++;
        $error("FAIL sb_extra observed=%h expected=none", flit_out);
      end else begin
        chk("sb_flit", flit_out, exp_q.pop_front());
      end
    end
  end

  task automatic send_req(input logic [3:0] dx, input logic [3:0] dy, input int len);
    int n;
    push_pkt(dx, dy, len);
    req_valid = 1'b1;
    req_dst_x = dx;
    req_dst_y = dy;
    req_len   = 8'(len);
    n = 0;
    forever begin
      @(negedge clk);
      if (req_ready) break;
      if (++n > 100) begin
        vec++; mis++;
        $error("FAIL req_timeout observed=0 expected=1");
        break;
      end
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic send_beat(input logic [61:0] d);
    int n;
    data_valid = 1'b1;
    data_in    = d;
    n = 0;
    forever begin
      @(negedge clk);
      if (data_ready) break;
      if (++n > 100) begin
        vec++; mis++;
        $error("FAIL beat_timeout observed=0 expected=1");
        break;
      end
    end
    @(posedge clk); #1;
    data_valid = 1'b0;
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 300; i++) begin
      if (exp_q.size() == 0) break;
      @(posedge clk); #1;
    end
    chk(tag, 64'(exp_q.size()), 64'd0);
  endtask

  task automatic chk_gapless(input string tag, input int base);
    for (int k = base + 1; k < acc_q.size(); k++)
      chk(tag, 64'(acc_q[k] - acc_q[k-1]), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    logic [63:0] held;
    logic [61:0] b;
    rst_n = 1'b0; req_valid = 1'b0; req_dst_x = '0; req_dst_y = '0; req_len = '0;
    data_valid = 1'b0; data_in = '0; ready_in = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", 64'(valid_out), 64'd0);
    chk("rst_flit", flit_out, 64'd0);
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    chk("rst_data_ready", 64'(data_ready), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 1: basic len=2 packet, gapless
    pay.delete(); pay.push_back(62'h0AAA_5555_1234_5678); pay.push_back(62'h3BBB_0000_FFFF_0001);
    base = acc_q.size();
    send_req(4'd3, 4'd2, 2);
    send_beat(pay[0]);
    send_beat(pay[1]);
    drain("t1_drain");
    chk_gapless("t1_gap", base);

    // 2: len=0, busy width and back-to-back acceptance
    pay.delete();
    send_req(4'd1, 4'd5, 0);
    @(negedge clk);
    chk("t2_busy_on", 64'(busy), 64'd1);
    @(posedge clk); #1;
    @(negedge clk);
`ifdef NOC_PKT_CRC_EN
    chk("t2_busy_next", 64'(busy), 64'd1);
`else
    chk("t2_busy_next", 64'(busy), 64'd0);
`endif
    @(posedge clk); #1;
    drain("t2_drain_a");
    base = acc_q.size();
    send_req(4'd7, 4'd0, 0);
    send_req(4'd0, 4'd7, 0);
    drain("t2_drain_b");
    chk_gapless("t2_gap", base);

    // 3: len=4 with a 5-cycle stall mid-packet
    pay.delete();
    for (int i = 0; i < 4; i++) pay.push_back(62'(64'h1111_0000_0000_0000 * (i + 1) + i));
    send_req(4'd2, 4'd9, 4);
    send_beat(pay[0]);
    ready_in   = 1'b0;
    held       = {2'b01, pay[0]};
    data_valid = 1'b1;
    data_in    = pay[1];
    req_valid  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t3_hold_flit", flit_out, held);
      chk("t3_hold_valid", 64'(valid_out), 64'd1);
      chk("t3_data_ready", 64'(data_ready), 64'd0);
      chk("t3_req_ready", 64'(req_ready), 64'd0);
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    ready_in  = 1'b1;
    send_beat(pay[1]);
    send_beat(pay[2]);
    send_beat(pay[3]);
    drain("t3_drain");

    // 4: two back-to-back len=1 packets
    pay.delete(); pay.push_back(62'h1357_9BDF_2468_ACE0);
    base = acc_q.size();
    send_req(4'd4, 4'd4, 1);
    send_beat(pay[0]);
    send_req(4'd5, 4'd6, 1);
    send_beat(pay[0]);
    drain("t4_drain");
    chk_gapless("t4_gap", base);

    // 5: asynchronous reset during the body of a len=3 packet
    pay.delete();
    for (int i = 0; i < 3; i++) pay.push_back(62'(64'hC0DE_0000 + i));
    send_req(4'd8, 4'd1, 3);
    send_beat(pay[0]);
    rst_n = 1'b0;
    #1;
    chk("t5_rst_valid", 64'(valid_out), 64'd0);
    chk("t5_rst_busy", 64'(busy), 64'd0);
    exp_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    pay.delete(); pay.push_back(62'h2FED_CBA9_8765_4321);
    send_req(4'd6, 4'd3, 1);
    send_beat(pay[0]);
    drain("t5_drain");

    // 6: len=1 with a zero beat (exercises the CRC tail when enabled)
    pay.delete(); b = '0; pay.push_back(b);
    send_req(4'd15, 4'd15, 1);
    send_beat(pay[0]);
    drain("t6_drain");

    // data offered while idle must be ignored
    data_valid = 1'b1;
    data_in    = 62'h3FFF_FFFF_FFFF_FFFF;
    @(negedge clk);
    chk("idle_data_ready", 64'(data_ready), 64'd0);
    repeat (3) @(posedge clk);
    #1;
    data_valid = 1'b0;
    @(negedge clk);
    chk("idle_no_flit", 64'(valid_out), 64'd0);
    chk("idle_busy", 64'(busy), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec, mis);
    $finish;
  end

endmodule
